// File: rtl/temporal_digit_slicer_if.sv
// Operand-in / digit-out handshake bundle for the temporal digit slicer.
// The slave modport is the slicer; the master modport is its environment.
interface temporal_digit_slicer_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int DIGIT_WIDTH = 2
);
    localparam int NUM_DIGITS = DATA_WIDTH / DIGIT_WIDTH;
    localparam int IDX_WIDTH  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_WIDTH-1:0]  in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [DIGIT_WIDTH:0]   out_digit;
    logic [IDX_WIDTH-1:0]   out_idx;
    logic                   out_first;
    logic                   out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_digit, out_idx, out_first, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_digit, out_idx, out_first, out_last
    );
endinterface

// File: rtl/temporal_digit_slicer.sv
// Slices a signed operand into DIGIT_WIDTH-bit digits, LSB digit first; low
// digits are unsigned and the top digit carries the sign for recombination.
module temporal_digit_slicer #(
    parameter int DATA_WIDTH  = 8,
    parameter int DIGIT_WIDTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    temporal_digit_slicer_if.slave bus
);
    localparam int NUM_DIGITS = DATA_WIDTH / DIGIT_WIDTH;
    localparam int IDX_WIDTH  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_DIGITS - 1);

    generate
        if ((DATA_WIDTH % DIGIT_WIDTH) != 0 || NUM_DIGITS < 2) begin : g_bad_params
            $error("temporal_digit_slicer: DATA_WIDTH must be a multiple of DIGIT_WIDTH with at least two digits");
        end
    endgenerate

    typedef enum logic {IDLE, EMIT} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [DATA_WIDTH-1:0]  hold_reg;
    logic [DATA_WIDTH-1:0]  hold_next;
    logic [IDX_WIDTH-1:0]   idx_reg;
    logic [IDX_WIDTH-1:0]   idx_next;
    logic [DIGIT_WIDTH-1:0] low_bits;
    logic                   emitting;
    logic                   at_last;

    assign emitting = (state == EMIT);
    assign at_last  = emitting && (idx_reg == LAST_IDX);
    assign low_bits = hold_reg[DIGIT_WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_reg <= '0;
            idx_reg  <= '0;
        end else begin
            state    <= state_next;
            hold_reg <= hold_next;
            idx_reg  <= idx_next;
        end
    end

    // Finishing the last digit and accepting a new operand share one edge,
    // which is what gives back-to-back operands without a bubble.
    always_comb begin
        state_next = state;
        hold_next  = hold_reg;
        idx_next   = idx_reg;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    hold_next  = bus.in_data;
                    idx_next   = '0;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    if (!at_last) begin
                        hold_next = hold_reg >> DIGIT_WIDTH;
                        idx_next  = idx_reg + IDX_WIDTH'(1);
                    end else if (bus.in_valid) begin
                        hold_next = bus.in_data;
                        idx_next  = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.in_ready  = !emitting || (at_last && bus.out_ready);
    assign bus.out_valid = emitting;
    assign bus.out_first = emitting && (idx_reg == '0);
    assign bus.out_last  = at_last;
    assign bus.out_idx   = emitting ? idx_reg : '0;

    // Only the top digit is sign-extended; the others are plain magnitudes.
    assign bus.out_digit = !emitting ? '0 :
                           at_last   ? {low_bits[DIGIT_WIDTH-1], low_bits} :
                                       {1'b0, low_bits};
endmodule
